msrv32_alu_issue: RTL and testbench
===================================

# msrv32_alu_issue

Registered operand-issue stage that drives the msrv32 ALU's `op_1_in`, `op_2_in` and `opcode_in` inputs. It takes a fetched instruction with its PC and register-file read data, decodes the 4-bit ALU opcode, and selects the two ALU operands. Results are presented through a valid/ready handshake backed by a 2-entry skid buffer, so the upstream side never sees a combinational ready path from the downstream side. It sits between the register-file read and the ALU/writeback stage.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `ms_riscv32_mp_clk_in`  in  1  clock
- `ms_riscv32_mp_rst_in`  in  1  synchronous, active-high reset
- `flush_in`  in  1  synchronous; discards all buffered entries
- `in_valid_in`  in  1  upstream presents an instruction
- `in_ready_out`  out  1  issue stage can accept
- `instr_in`  in  32  instruction word
- `pc_in`  in  XLEN  PC of the instruction
- `rs1_in` / `rs2_in`  in  XLEN  register read data
- `out_valid_out`  out  1  issued operation valid
- `out_ready_in`  in  1  ALU/writeback stage accepts
- `op_1_out` / `op_2_out`  out  XLEN  ALU operands
- `opcode_out`  out  4  ALU opcode
- `rd_out`  out  5  destination register
- `wr_en_out`  out  1  writeback enable
- `illegal_out`  out  1  instruction not handled by this stage

## Operation
- ALU opcode is `{bit30, funct3}`:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- OP (0110011):
  - `op_1` = rs1, `op_2` = rs2, opcode = `{instr[30], funct3}`.
  - Legal only if funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}.
- OP-IMM (0010011):
  - `op_1` = rs1, `op_2` = sign-extended `instr[31:20]`.
  - For funct3 001/101: `op_2` = zero-extended shamt `instr[24:20]`, opcode bit3 = `instr[30]`. Legal only if `instr[31:25]` = 0000000, or 0100000 with funct3 = 101.
  - All other funct3 values: opcode bit3 = 0.
- LUI (0110111): `op_1` = 0, `op_2` = `{instr[31:12], 12'b0}`, opcode ADD.
- AUIPC (0010111): `op_1` = pc, `op_2` = `{instr[31:12], 12'b0}`, opcode ADD.
- Any other major opcode or an illegal encoding:
  - Entry is still issued with `illegal_out` = 1, `wr_en_out` = 0, opcode ADD, both operands 0.
- `wr_en_out` = legal AND rd ≠ 0.
- Skid buffer states:
  - EMPTY: output register and skid register both empty.
  - ONE: output register full.
  - TWO: output register and skid register both full.
- State transitions:
  - EMPTY + in_fire → ONE.
  - ONE + in_fire + out_fire → ONE (output register reloads).
  - ONE + out_fire only → EMPTY.
  - ONE + in_fire only → TWO (new entry goes to skid).
  - TWO + out_fire → ONE (skid moves to output register).
- in_fire = `in_valid_in & in_ready_out`; out_fire = `out_valid_out & out_ready_in`.
- `in_ready_out` = (state ≠ TWO). It is registered and does not depend on `out_ready_in` in the same cycle.
- Order is strictly FIFO; no entry is dropped or duplicated.

## Timing
- Latency: 1 cycle from in_fire to `out_valid_out` when EMPTY.
- Throughput: 1 operation per cycle while `out_ready_in` = 1.
- Outputs are registered, and held stable while `out_valid_out` = 1 and `out_ready_in` = 0.
- Reset:
  - State → EMPTY.
  - `out_valid_out`, `op_1_out`, `op_2_out`, `opcode_out`, `rd_out`, `wr_en_out`, `illegal_out` all = 0.
  - `in_ready_out` = 1 in the first cycle after reset.
- `flush_in`:
  - Next state is EMPTY and all outputs are zeroed as on reset.
  - An in_fire in the same cycle is discarded.
  - Reset has priority over flush.
- Reset or flush mid-stream (state TWO) loses both entries; no partial output appears.

## Structure
- Shared package `msrv32_pkg`:
  - Major-opcode localparams: OP, OP_IMM, LUI, AUIPC.
  - ALU opcode localparams: ALU_ADD … ALU_AND.
  - Skid state encoding.
  - The package is shared with the ALU and the decoder.
- Sub-module `msrv32_alu_op_decode`: purely combinational; instr/pc/rs1/rs2 → op_1, op_2, opcode, rd, wr_en, illegal.
- Top level holds the skid FSM and the two payload registers.

## Test plan
- ADD, then SUB:
  - `0x002081B3` with rs1 = 10, rs2 = 20 → next cycle `op_1` = 10, `op_2` = 20, opcode 0000, rd 3, wr_en 1.
  - `0x402081B3` → opcode 1000.
- SRAI / ADDI / LUI:
  - SRAI `0x4050D293` with rs1 = 0x80000000 → `op_2` = 5, opcode 1101.
  - ADDI `0xFFB00093` → `op_2` = 0xFFFFFFFB, opcode 0000, rd 1.
  - LUI `0x123453B7` → `op_1` = 0, `op_2` = 0x12345000.
- Backpressure:
  - Hold `out_ready_in` = 0 and issue 3 back-to-back valid instructions.
  - `in_ready_out` drops after the 2nd is accepted; the 3rd is held upstream.
  - Outputs stay stable on the 1st.
  - Release `out_ready_in` → all 3 emerge in order, with no gaps once streaming.
- Illegal and rd = x0:
  - `0x0000007F` → `illegal_out` = 1, `wr_en_out` = 0, operands 0.
  - `add x0, x1, x2` (`0x00208033`) → legal, `wr_en_out` = 0.
- Flush / reset:
  - With state TWO, assert `flush_in` together with a new in_valid → next cycle `out_valid_out` = 0, `in_ready_out` = 1, and no entry emerges later.
  - Repeat with reset → same result, all outputs 0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared msrv32 encodings: RV32I major opcodes, 4-bit ALU opcodes, and the
// skid-buffer state used by the operand-issue stage.
package msrv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // ALU opcode is {instr[30], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/msrv32_alu_op_decode.sv
// Combinational decode of an RV32I instruction into ALU operands/opcode.
// Anything this stage does not handle comes out as an illegal, zero-operand ADD.
module msrv32_alu_op_decode
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic [XLEN-1:0] op_1_out,
  output logic [XLEN-1:0] op_2_out,
  output logic [3:0]      opcode_out,
  output logic [4:0]      rd_out,
  output logic            wr_en_out,
  output logic            illegal_out
);

  logic [6:0]             w_major;
  logic [2:0]             w_f3;
  logic [6:0]             w_f7;
  logic signed [XLEN-1:0] w_imm_i;
  logic signed [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0]        w_shamt;
  logic                   w_legal;

  assign w_major = instr_in[6:0];
  assign w_f3    = instr_in[14:12];
  assign w_f7    = instr_in[31:25];
  assign rd_out  = instr_in[11:7];

  assign w_imm_i = XLEN'($signed(instr_in[31:20]));
  assign w_imm_u = XLEN'($signed({instr_in[31:12], 12'b0}));
  assign w_shamt = XLEN'(instr_in[24:20]);

  always_comb begin
    op_1_out   = '0;
    op_2_out   = '0;
    opcode_out = ALU_ADD;
    w_legal    = 1'b0;
    case (w_major)
      OP: begin
        w_legal    = (w_f7 == 7'b0000000) ||
                     ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        op_1_out   = rs1_in;
        op_2_out   = rs2_in;
        opcode_out = {instr_in[30], w_f3};
      end
      OP_IMM: begin
        op_1_out = rs1_in;
        // Shifts carry shamt in the immediate; bit30 selects SRA vs SRL
        if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
          w_legal    = (w_f7 == 7'b0000000) ||
                       ((w_f7 == 7'b0100000) && (w_f3 == 3'b101));
          op_2_out   = w_shamt;
          opcode_out = {instr_in[30], w_f3};
        end else begin
          w_legal    = 1'b1;
          op_2_out   = w_imm_i;
          opcode_out = {1'b0, w_f3};
        end
      end
      LUI: begin
        w_legal  = 1'b1;
        op_2_out = w_imm_u;
      end
      AUIPC: begin
        w_legal  = 1'b1;
        op_1_out = pc_in;
        op_2_out = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      op_1_out   = '0;
      op_2_out   = '0;
      opcode_out = ALU_ADD;
    end
  end

  assign wr_en_out   = w_legal && (instr_in[11:7] != 5'd0);
  assign illegal_out = !w_legal;

endmodule

// File: rtl/msrv32_alu_issue.sv
// Registered ALU operand-issue stage with a 2-entry skid buffer so that
// in_ready_out is a flop and never sees out_ready_in combinationally.
module msrv32_alu_issue
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            flush_in,
  input  logic            in_valid_in,
  output logic            in_ready_out,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            out_valid_out,
  input  logic            out_ready_in,
  output logic [XLEN-1:0] op_1_out,
  output logic [XLEN-1:0] op_2_out,
  output logic [3:0]      opcode_out,
  output logic [4:0]      rd_out,
  output logic            wr_en_out,
  output logic            illegal_out
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      opcode;
    logic [4:0]      rd;
    logic            wr_en;
    logic            illegal;
  } payload_t;

  payload_t    w_dec_p0;
  payload_t    r_out_p1;
  payload_t    r_skid_p1;
  skid_state_e r_state;
  skid_state_e w_state_n;
  logic        r_in_rdy;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_load_out;
  logic        w_load_skid;
  logic        w_skid_to_out;

  msrv32_alu_op_decode #(.XLEN(XLEN)) u_decode (
    .instr_in    (instr_in),
    .pc_in       (pc_in),
    .rs1_in      (rs1_in),
    .rs2_in      (rs2_in),
    .op_1_out    (w_dec_p0.op1),
    .op_2_out    (w_dec_p0.op2),
    .opcode_out  (w_dec_p0.opcode),
    .rd_out      (w_dec_p0.rd),
    .wr_en_out   (w_dec_p0.wr_en),
    .illegal_out (w_dec_p0.illegal)
  );

  assign out_valid_out = (r_state != SKID_EMPTY);
  assign in_ready_out  = r_in_rdy;
  assign w_in_fire     = in_valid_in && r_in_rdy;
  assign w_out_fire    = out_valid_out && out_ready_in;

  always_comb begin
    w_state_n     = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_in_fire) begin
          w_state_n  = SKID_ONE;
          w_load_out = 1'b1;
        end
      end
      SKID_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_out = 1'b1;
        end else if (w_out_fire) begin
          w_state_n = SKID_EMPTY;
        end else if (w_in_fire) begin
          w_state_n   = SKID_TWO;
          w_load_skid = 1'b1;
        end
      end
      SKID_TWO: begin
        if (w_out_fire) begin
          w_state_n     = SKID_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_n = SKID_EMPTY;
    endcase
    if (flush_in) begin
      w_state_n     = SKID_EMPTY;
      w_load_out    = 1'b0;
      w_load_skid   = 1'b0;
      w_skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state  <= SKID_EMPTY;
      r_in_rdy <= 1'b1;
    end else begin
      r_state  <= w_state_n;
      r_in_rdy <= (w_state_n != SKID_TWO);
    end
  end

  // p0 -> p1: output register and skid register
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in || flush_in) begin
      r_out_p1 <= '0;
    end else if (w_load_out) begin
      r_out_p1 <= w_dec_p0;
    end else if (w_skid_to_out) begin
      r_out_p1 <= r_skid_p1;
    end
    if (w_load_skid) begin
      r_skid_p1 <= w_dec_p0;
    end
  end

  assign op_1_out    = r_out_p1.op1;
  assign op_2_out    = r_out_p1.op2;
  assign opcode_out  = r_out_p1.opcode;
  assign rd_out      = r_out_p1.rd;
  assign wr_en_out   = r_out_p1.wr_en;
  assign illegal_out = r_out_p1.illegal;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Scoreboard bench for msrv32_alu_issue: a reference decode model pushes
// expected payloads on in_fire, compared in order on out_fire.
module tb_msrv32_alu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr, pc, rs1, rs2;
  logic        in_ready, out_valid, wr_en, illegal;
  logic [31:0] op_1, op_2;
  logic [3:0]  opcode;
  logic [4:0]  rd;

  int n_chk = 0;
  int n_err = 0;
  logic [74:0] sb_q[$];
  wire  [74:0] dut_pay = {op_1, op_2, opcode, rd, wr_en, illegal};

  always #5 clk = ~clk;

  msrv32_alu_issue #(.XLEN(32)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .flush_in             (flush),
    .in_valid_in          (in_valid),
    .in_ready_out         (in_ready),
    .instr_in             (instr),
    .pc_in                (pc),
    .rs1_in               (rs1),
    .rs2_in               (rs2),
    .out_valid_out        (out_valid),
    .out_ready_in         (out_ready),
    .op_1_out             (op_1),
    .op_2_out             (op_2),
    .opcode_out           (opcode),
    .rd_out               (rd),
    .wr_en_out            (wr_en),
    .illegal_out          (illegal)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [74:0] model(input logic [31:0] ins, input logic [31:0] pcv,
                                        input logic [31:0] a, input logic [31:0] b);
    logic        ok;
    logic [31:0] x1, x2;
    logic [3:0]  op;
    ok = 1'b0; x1 = '0; x2 = '0; op = 4'b0000;
    case (ins[6:0])
      7'h33: begin
        ok = (ins[31:25] == 7'h00) ||
             (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5));
        x1 = a; x2 = b; op = {ins[30], ins[14:12]};
      end
      7'h13: begin
        x1 = a;
        case (ins[14:12])
          3'd1: begin ok = (ins[31:25] == 7'h00); x2 = {27'b0, ins[24:20]}; op = 4'b0001; end
          3'd5: begin
            ok = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
            x2 = {27'b0, ins[24:20]}; op = {ins[30], 3'b101};
          end
          default: begin ok = 1'b1; x2 = {{20{ins[31]}}, ins[31:20]}; op = {1'b0, ins[14:12]}; end
        endcase
      end
      7'h37: begin ok = 1'b1; x2 = {ins[31:12], 12'h000}; end
      7'h17: begin ok = 1'b1; x1 = pcv; x2 = {ins[31:12], 12'h000}; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin x1 = '0; x2 = '0; op = 4'b0000; end
    return {x1, x2, op, ins[11:7], ok && (ins[11:7] != 5'd0), !ok};
  endfunction

  // Scoreboard: pop on out_fire, push on in_fire; reset/flush empties it
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("spurious_out", out_valid, 1'b0);
        else                  check("sb_payload", dut_pay, sb_q.pop_front());
      end
      if (in_valid && in_ready) sb_q.push_back(model(instr, pc, rs1, rs2));
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; instr = i; pc = p; rs1 = a; rs2 = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", {127'b0, acc}, 128'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [74:0] held;
    logic [4:0]  vstream;
    bit          acc;
    time         t0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_payload", dut_pay, 75'd0);

    // ADD with 1-cycle latency
    @(posedge clk); #1;
    send(32'h002081B3, 32'h100, 32'd10, 32'd20);
    @(negedge clk);
    check("add_valid", out_valid, 1'b1);
    check("add_op1", op_1, 32'd10);
    check("add_op2", op_2, 32'd20);
    check("add_opcode", opcode, 4'b0000);
    check("add_rd", rd, 5'd3);
    check("add_wr_en", wr_en, 1'b1);
    @(posedge clk); #1;

    // Back-to-back stream at full throughput
    t0 = $time;
    send(32'h402081B3, 32'h104, 32'd5, 32'd3);          // SUB
    send(32'h4050D293, 32'h108, 32'h80000000, 32'd0);   // SRAI
    send(32'hFFB00093, 32'h10C, 32'd7, 32'd0);          // ADDI -5
    send(32'h123453B7, 32'h110, 32'hDEAD, 32'hBEEF);    // LUI
    send(32'h00001297, 32'h2000, 32'd1, 32'd2);         // AUIPC
    send(32'h0000007F, 32'h114, 32'd9, 32'd9);          // illegal major
    send(32'h00208033, 32'h118, 32'd4, 32'd6);          // add x0
    send(32'h042081B3, 32'h11C, 32'd4, 32'd6);          // bad funct7
    send(32'h40109093, 32'h120, 32'd4, 32'd6);          // SLLI with bit30
    send(32'h0020D1B3, 32'h124, 32'hF0, 32'd4);         // SRL
    check("throughput", ($time - t0) / 10, 10);
    repeat (3) @(posedge clk); #1;
    check("stream_drain", sb_q.size(), 0);

    // Backpressure: three back-to-back, downstream stalled
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h200; rs1 = 32'hA1; rs2 = 32'd1;
    @(negedge clk); check("bp_ready_a", in_ready, 1'b1);
    @(posedge clk); #1 rs1 = 32'hA2;
    @(negedge clk); check("bp_ready_b", in_ready, 1'b1);
    held = dut_pay;
    @(posedge clk); #1 rs1 = 32'hA3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready_low", in_ready, 1'b0);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_op1", op_1, 32'hA1);
      check("bp_hold_pay", dut_pay, held);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vstream[k] = out_valid;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("bp_stream", vstream, 5'b00111);
    check("bp_drain", sb_q.size(), 0);

    // Flush in state TWO with a new valid presented
    out_ready = 1'b0;
    send(32'h002081B3, 32'h300, 32'hB1, 32'd0);
    send(32'h002081B3, 32'h304, 32'hB2, 32'd0);
    in_valid = 1'b1; instr = 32'h002081B3; rs1 = 32'hB3; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("fl2_valid", out_valid, 1'b0);
    check("fl2_ready", in_ready, 1'b1);
    check("fl2_payload", dut_pay, 75'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("fl2_quiet", out_valid, 1'b0);
    end

    // Flush in state ONE discards a same-cycle in_fire
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h002081B3, 32'h400, 32'hC1, 32'd0);
    in_valid = 1'b1; rs1 = 32'hC2; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("fl1_quiet", out_valid, 1'b0);
    end

    // Reset in state TWO
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h4050D293, 32'h500, 32'hD1, 32'd0);
    send(32'h002081B3, 32'h504, 32'hD2, 32'd0);
    in_valid = 1'b1; rs1 = 32'hD3; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst2_valid", out_valid, 1'b0);
    check("rst2_ready", in_ready, 1'b1);
    check("rst2_payload", dut_pay, 75'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("rst2_quiet", out_valid, 1'b0);
    end

    // Normal operation resumes after reset
    @(posedge clk); #1;
    send(32'h00208033, 32'h600, 32'd11, 32'd12);
    send(32'hFFB00093, 32'h604, 32'd13, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("final_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
